// File: rtl/axi_perf_pkg.sv
// Shared types and default widths for the AXI performance-bench traffic generators.
package axi_perf_pkg;

    localparam int AXI_ID_WTH   = 4;
    localparam int AXI_ADDR_WTH = 32;
    localparam int AXI_LEN_WTH  = 8;
    localparam int AXI_DATA_WTH = 512;
    localparam int AXI_RESP_WTH = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

endpackage

// File: rtl/axi_rd_burst_gen_if.sv
// AXI read-address and read-data channels between a traffic master and a memory slave.
interface AXI_intf
    import axi_perf_pkg::*;
#(
    parameter int ID_WTH   = AXI_ID_WTH,
    parameter int ADDR_WTH = AXI_ADDR_WTH,
    parameter int LEN_WTH  = AXI_LEN_WTH,
    parameter int DATA_WTH = AXI_DATA_WTH,
    parameter int RESP_WTH = AXI_RESP_WTH
) ();

    logic [ID_WTH-1:0]   arid;
    logic [ADDR_WTH-1:0] araddr;
    logic [LEN_WTH-1:0]  arlen;
    logic                arvalid;
    logic                arready;
    logic [ID_WTH-1:0]   rid;
    logic [DATA_WTH-1:0] rdata;
    logic [RESP_WTH-1:0] rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output arid, araddr, arlen, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_rd_resp_chk.sv
// R-channel checker: beat-in-burst tracking, rlast/rresp error flag, beat count and data signature.
module axi_rd_resp_chk
    import axi_perf_pkg::*;
#(
    parameter int LEN_WTH  = AXI_LEN_WTH,
    parameter int DATA_WTH = AXI_DATA_WTH,
    parameter int RESP_WTH = AXI_RESP_WTH,
    parameter int CNT_WTH  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                r_hs,
    input  logic [LEN_WTH-1:0]  burst_len,
    input  logic [DATA_WTH-1:0] rdata,
    input  logic [RESP_WTH-1:0] rresp,
    input  logic                rlast,
    output logic                err,
    output logic [CNT_WTH-1:0]  beat_count,
    output logic [DATA_WTH-1:0] data_sig
);

    logic [LEN_WTH-1:0]  beat_q, beat_d;
    logic                err_q, err_d;
    logic [CNT_WTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WTH-1:0] sig_q, sig_d;
    logic                beat_err;

    // rlast must coincide with the final beat; any non-OKAY response is also an error.
    assign beat_err = (rlast != (beat_q == burst_len)) ||
                      (rresp != RESP_WTH'(AXI_RESP_OKAY));

    // Next-state for the per-run R-channel bookkeeping.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
        beat_d = beat_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        sig_d  = sig_q;
        if (clear) begin
            beat_d = '0;
            err_d  = 1'b0;
            cnt_d  = '0;
            sig_d  = '0;
        end else if (r_hs) begin
            cnt_d  = cnt_q + CNT_WTH'(1);
            sig_d  = sig_q ^ rdata;
            beat_d = rlast ? '0 : beat_q + LEN_WTH'(1);
            if (beat_err) begin
                err_d = 1'b1;
            end
        end
    end

    // Checker registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (rst) begin
            beat_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            sig_q  <= '0;
        end else begin
            beat_q <= beat_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            sig_q  <= sig_d;
        end
    end

    assign err        = err_q;
    assign beat_count = cnt_q;
    assign data_sig   = sig_q;

endmodule

// File: rtl/axi_rd_burst_gen.sv
// Read-traffic generator: issues equal-length INCR bursts with bounded outstanding requests.
module axi_rd_burst_gen
    import axi_perf_pkg::*;
#(
    parameter int ID_WTH          = AXI_ID_WTH,
    parameter int ADDR_WTH        = AXI_ADDR_WTH,
    parameter int LEN_WTH         = AXI_LEN_WTH,
    parameter int DATA_WTH        = AXI_DATA_WTH,
    parameter int RESP_WTH        = AXI_RESP_WTH,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WTH         = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                start,
    input  logic [ADDR_WTH-1:0] base_addr,
    input  logic [CNT_WTH-1:0]  num_bursts,
    input  logic [LEN_WTH-1:0]  burst_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_WTH-1:0]  beat_count,
    output logic [CNT_WTH-1:0]  cycle_count,
    output logic [DATA_WTH-1:0] data_sig,
    AXI_intf.master             axi
);

    localparam logic [7:0]          MAX_OUT    = 8'(MAX_OUTSTANDING);
    localparam logic [ADDR_WTH-1:0] BEAT_BYTES = ADDR_WTH'(DATA_WTH / 8);

    gen_state_e          state_q, state_d;
    logic [CNT_WTH-1:0]  num_q, num_d;
    logic [CNT_WTH-1:0]  issued_q, issued_d;
    logic [CNT_WTH-1:0]  completed_q, completed_d;
    logic [CNT_WTH-1:0]  cycle_q, cycle_d;
    logic [7:0]          outst_q, outst_d;
    logic [ADDR_WTH-1:0] araddr_q, araddr_d;
    logic [LEN_WTH-1:0]  len_q, len_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_WTH-1:0] step;
    logic                start_acc, ar_hs, r_hs, rlast_hs;

    // Handshakes only count on enabled cycles; rready equals busy.
    assign start_acc = ce && start && (state_q == ST_IDLE);
    assign ar_hs     = ce && arvalid_q && axi.arready;
    assign r_hs      = ce && busy && axi.rvalid;
    assign rlast_hs  = r_hs && axi.rlast;

    // Byte distance between consecutive bursts; wraps with the address width.
    assign step = (ADDR_WTH'(len_q) + ADDR_WTH'(1)) * BEAT_BYTES;

    // Datapath next-state: run parameters, AR issue, outstanding/issued/completed/cycle counters.
    always_comb begin
        num_d       = num_q;
        len_d       = len_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        outst_d     = outst_q;
        cycle_d     = cycle_q;
        if (start_acc) begin
            num_d       = num_bursts;
            len_d       = burst_len;
            araddr_d    = base_addr;
            issued_d    = '0;
            completed_d = '0;
            outst_d     = '0;
            cycle_d     = '0;
            arvalid_d   = (num_bursts != '0);
        end else if (ce && busy) begin
            cycle_d = cycle_q + CNT_WTH'(1);
            if (ar_hs) begin
                issued_d = issued_q + CNT_WTH'(1);
                araddr_d = araddr_q + step;
            end
            if (ar_hs && !rlast_hs) begin
                outst_d = outst_q + 8'd1;
            end else if (!ar_hs && rlast_hs) begin
                outst_d = outst_q - 8'd1;
            end
            if (rlast_hs) begin
                completed_d = completed_q + CNT_WTH'(1);
            end
            // A raised request is held until accepted; only then is the next one considered.
            if (!arvalid_q || ar_hs) begin
                arvalid_d = (state_q == ST_RUN) && (issued_d < num_q) && (outst_d < MAX_OUT);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q       <= '0;
            len_q       <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            issued_q    <= '0;
            completed_q <= '0;
            outst_q     <= '0;
            cycle_q     <= '0;
        end else begin
            num_q       <= num_d;
            len_q       <= len_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            outst_q     <= outst_d;
            cycle_q     <= cycle_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; decisions use post-edge counter values so done follows the last rlast directly.
    always_comb begin
        state_d = state_q;
        if (ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (num_bursts == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((issued_d == num_q) && !arvalid_d) begin
                        state_d = (completed_d == num_q) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (completed_d == num_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        axi.rready = busy;
    end

    assign axi.arid    = ID_WTH'(0);
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = len_q;
    assign axi.arvalid = arvalid_q;
    assign cycle_count = cycle_q;

    axi_rd_resp_chk #(
        .LEN_WTH  (LEN_WTH),
        .DATA_WTH (DATA_WTH),
        .RESP_WTH (RESP_WTH),
        .CNT_WTH  (CNT_WTH)
    ) u_resp_chk (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_acc),
        .r_hs       (r_hs),
        .burst_len  (len_q),
        .rdata      (axi.rdata),
        .rresp      (axi.rresp),
        .rlast      (axi.rlast),
        .err        (err),
        .beat_count (beat_count),
        .data_sig   (data_sig)
    );

endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// Scoreboard bench: expected AR requests and run results are queued; monitors pop and compare.
module tb_axi_rd_burst_gen;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [31:0]  beats;
        logic         err;
        logic [511:0] sig;
        logic [31:0]  cyc;
        bit           chk_cyc;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [31:0]  num_bursts = '0;
    logic [7:0]   burst_len = '0;
    logic         busy, done, err;
    logic [31:0]  beat_count, cycle_count;
    logic [511:0] data_sig;

    AXI_intf #(.ID_WTH(4), .ADDR_WTH(32), .LEN_WTH(8), .DATA_WTH(512), .RESP_WTH(2)) axi ();

    axi_rd_burst_gen #(
        .ID_WTH(4), .ADDR_WTH(32), .LEN_WTH(8), .DATA_WTH(512), .RESP_WTH(2),
        .MAX_OUTSTANDING(2), .CNT_WTH(32)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start),
        .base_addr(base_addr), .num_bursts(num_bursts), .burst_len(burst_len),
        .busy(busy), .done(done), .err(err),
        .beat_count(beat_count), .cycle_count(cycle_count), .data_sig(data_sig),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned ar_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned last_rlast_cyc = 0;

    ar_t  exp_ar[$];
    res_t exp_res[$];

    // Slave knobs, written only by the stimulus process.
    logic arready_en = 1'b1;
    logic rvalid_en = 1'b1;
    logic early_last_en = 1'b0;
    logic bad_resp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] sig_of(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        exp_ar.push_back(a);
    endtask

    task automatic push_res(input logic [31:0] beats, input logic e, input logic [31:0] w,
                            input logic [31:0] c, input bit chk);
        res_t r;
        r.beats = beats; r.err = e; r.sig = sig_of(w); r.cyc = c; r.chk_cyc = chk;
        exp_res.push_back(r);
    endtask

    task automatic run_start(input logic [31:0] base, input logic [31:0] nb, input logic [7:0] len);
        @(posedge clk); #1;
        base_addr = base; num_bursts = nb; burst_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(name, 512'(seen), 512'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // AR monitor: every address handshake is compared against the next queued request.
    always @(negedge clk) begin
        if (!rst && ce && axi.arvalid && axi.arready) begin
            ar_t a;
            ar_cnt++;
            check("ar_expected", 512'(exp_ar.size() != 0), 512'd1);
            if (exp_ar.size() != 0) begin
                a = exp_ar.pop_front();
                check("araddr", 512'(axi.araddr), 512'(a.addr));
                check("arlen", 512'(axi.arlen), 512'(a.len));
            end
        end
    end

    // Done monitor: every completion pulse is compared against the next queued run result.
    always @(negedge clk) begin
        if (done) begin
            res_t r;
            done_cnt++;
            check("done_expected", 512'(exp_res.size() != 0), 512'd1);
            if (exp_res.size() != 0) begin
                r = exp_res.pop_front();
                check("beat_count", 512'(beat_count), 512'(r.beats));
                check("err", 512'(err), 512'(r.err));
                check("data_sig", data_sig, r.sig);
                check("done_busy_low", 512'(busy), 512'd0);
                if (r.chk_cyc) check("cycle_count", 512'(cycle_count), 512'(r.cyc));
                if (r.beats != 0) check("done_latency", 512'(cyc), 512'(last_rlast_cyc));
            end
        end
    end

    // Memory slave model: in-order bursts, one-hot data pattern, optional error injection.
    initial begin
        logic [7:0]  sq[$];
        int unsigned beat_glob = 0, burst_idx = 0, beat_in = 0;
        logic ar_hs_s, r_hs_s, rst_s, start_s, rlast_s;
        logic [7:0] arlen_s, eff_len;
        axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 1'b0; axi.rvalid = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs_s = ce && axi.arvalid && axi.arready;
            r_hs_s  = ce && axi.rvalid && axi.rready;
            rlast_s = axi.rlast;
            arlen_s = axi.arlen;
            rst_s   = rst;
            start_s = ce && start;
            @(posedge clk); #2;
            if (rst_s) begin
                sq.delete();
                beat_in = 0;
            end else begin
                if (start_s) begin
                    beat_glob = 0; burst_idx = 0; beat_in = 0;
                end
                if (r_hs_s) begin
                    beat_glob++;
                    if (rlast_s) begin
                        void'(sq.pop_front());
                        beat_in = 0;
                        burst_idx++;
                        last_rlast_cyc = cyc;
                    end else begin
                        beat_in++;
                    end
                end
                if (ar_hs_s) sq.push_back(arlen_s);
            end
            axi.arready = arready_en;
            if (!rst_s && rvalid_en && sq.size() != 0) begin
                eff_len     = (early_last_en && burst_idx == 0) ? 8'd2 : sq[0];
                axi.rvalid  = 1'b1;
                axi.rlast   = (beat_in == int'(eff_len));
                axi.rdata   = sig_of(32'h1 << (beat_glob % 32));
                axi.rresp   = (bad_resp_en && beat_glob == 1) ? 2'b10 : 2'b00;
            end else begin
                axi.rvalid  = 1'b0;
                axi.rlast   = 1'b0;
                axi.rresp   = 2'b00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ar_base, done_base;
        logic [31:0] frozen_cyc, frozen_beats;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        check("rst_err", 512'(err), 512'd0);
        check("rst_arvalid", 512'(axi.arvalid), 512'd0);
        check("rst_rready", 512'(axi.rready), 512'd0);
        check("rst_araddr", 512'(axi.araddr), 512'd0);
        check("rst_beat_count", 512'(beat_count), 512'd0);
        check("rst_cycle_count", 512'(cycle_count), 512'd0);
        check("rst_data_sig", data_sig, 512'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic run: 4 bursts of 4 beats from 0x1000.
        push_ar(32'h1000, 8'd3); push_ar(32'h1100, 8'd3);
        push_ar(32'h1200, 8'd3); push_ar(32'h1300, 8'd3);
        push_res(32'd16, 1'b0, 32'h0000_FFFF, 32'd17, 1);
        done_base = done_cnt;
        run_start(32'h1000, 32'd4, 8'd3);
        @(negedge clk);
        check("start_busy_latency", 512'(busy), 512'd1);
        check("start_arvalid_latency", 512'(axi.arvalid), 512'd1);
        wait_done("basic_done", 200);
        idle_cycles(3);
        check("basic_done_once", 512'(done_cnt - done_base), 512'd1);

        // Backpressure: arready withheld for 5 cycles.
        arready_en = 1'b0;
        push_ar(32'h2000, 8'd1); push_ar(32'h2080, 8'd1);
        push_res(32'd4, 1'b0, 32'h0000_000F, 32'd0, 0);
        ar_base = ar_cnt;
        run_start(32'h2000, 32'd2, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_arvalid", 512'(axi.arvalid), 512'd1);
            check("bp_araddr", 512'(axi.araddr), 512'h2000);
            check("bp_arlen", 512'(axi.arlen), 512'd1);
        end
        check("bp_no_issue", 512'(ar_cnt - ar_base), 512'd0);
        @(posedge clk); #1;
        arready_en = 1'b1;
        wait_done("bp_done", 200);

        // Outstanding limit: R withheld, only two requests may be accepted.
        rvalid_en = 1'b0;
        push_ar(32'h3000, 8'd0); push_ar(32'h3040, 8'd0);
        push_ar(32'h3080, 8'd0); push_ar(32'h30C0, 8'd0);
        push_res(32'd4, 1'b0, 32'h0000_000F, 32'd0, 0);
        ar_base = ar_cnt;
        run_start(32'h3000, 32'd4, 8'd0);
        idle_cycles(8);
        check("outst_ar_count", 512'(ar_cnt - ar_base), 512'd2);
        check("outst_arvalid_low", 512'(axi.arvalid), 512'd0);
        @(posedge clk); #1;
        rvalid_en = 1'b1;
        wait_done("outst_done", 200);

        // Early rlast on beat 2 of a len-3 burst.
        early_last_en = 1'b1;
        push_ar(32'h4000, 8'd3); push_ar(32'h4100, 8'd3);
        push_res(32'd7, 1'b1, 32'h0000_007F, 32'd0, 0);
        run_start(32'h4000, 32'd2, 8'd3);
        wait_done("early_done", 200);
        idle_cycles(3);
        check("early_err_held", 512'(err), 512'd1);
        @(posedge clk); #1;
        early_last_en = 1'b0;

        // Non-OKAY response on the second beat.
        bad_resp_en = 1'b1;
        push_ar(32'h5000, 8'd1);
        push_res(32'd2, 1'b1, 32'h0000_0003, 32'd3, 1);
        run_start(32'h5000, 32'd1, 8'd1);
        wait_done("resp_done", 200);
        @(posedge clk); #1;
        bad_resp_en = 1'b0;

        // Zero bursts: done right after start, no AR, previous err and signature cleared.
        push_res(32'd0, 1'b0, 32'h0, 32'd0, 1);
        ar_base = ar_cnt;
        run_start(32'h9000, 32'd0, 8'd3);
        @(negedge clk);
        check("zero_done_next_cycle", 512'(done), 512'd1);
        check("zero_busy", 512'(busy), 512'd0);
        idle_cycles(3);
        check("zero_no_ar", 512'(ar_cnt - ar_base), 512'd0);

        // Address wrap at the top of the address space.
        push_ar(32'hFFFF_FFC0, 8'd0); push_ar(32'h0000_0000, 8'd0);
        push_res(32'd2, 1'b0, 32'h0000_0003, 32'd3, 1);
        run_start(32'hFFFF_FFC0, 32'd2, 8'd0);
        wait_done("wrap_done", 200);

        // Clock enable low for 10 cycles mid-run.
        push_ar(32'h6000, 8'd3); push_ar(32'h6100, 8'd3);
        push_ar(32'h6200, 8'd3); push_ar(32'h6300, 8'd3);
        push_res(32'd16, 1'b0, 32'h0000_FFFF, 32'd17, 1);
        run_start(32'h6000, 32'd4, 8'd3);
        idle_cycles(3);
        @(posedge clk); #1;
        ce = 1'b0;
        @(negedge clk);
        frozen_cyc   = cycle_count;
        frozen_beats = beat_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ce_cycle_hold", 512'(cycle_count), 512'(frozen_cyc));
            check("ce_beat_hold", 512'(beat_count), 512'(frozen_beats));
            check("ce_busy_hold", 512'(busy), 512'd1);
        end
        @(posedge clk); #1;
        ce = 1'b1;
        idle_cycles(2);
        check("ce_cycle_resumes", 512'(cycle_count > frozen_cyc), 512'd1);
        wait_done("ce_done", 200);

        // Reset while draining.
        rvalid_en = 1'b0;
        push_ar(32'h7000, 8'd3); push_ar(32'h7100, 8'd3);
        run_start(32'h7000, 32'd2, 8'd3);
        idle_cycles(5);
        check("drain_busy", 512'(busy), 512'd1);
        check("drain_arvalid", 512'(axi.arvalid), 512'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_drain_arvalid", 512'(axi.arvalid), 512'd0);
        check("rst_drain_rready", 512'(axi.rready), 512'd0);
        check("rst_drain_busy", 512'(busy), 512'd0);
        @(posedge clk); #1;
        rvalid_en = 1'b1;
        idle_cycles(5);

        check("ar_queue_drained", 512'(exp_ar.size()), 512'd0);
        check("res_queue_drained", 512'(exp_res.size()), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
